// File: rtl/mips_wb_pkg.sv
// Shared opcodes, buffer entry type and lane helpers for the MIPS load/writeback stage.
// Byte lanes are numbered big-endian-agnostic: be[3] covers data[31:24], be[0] covers data[7:0].
package mips_wb_pkg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    typedef enum logic [2:0] {
        WB_OP_ALU = 3'd0,
        WB_OP_LB  = 3'd1,
        WB_OP_LBU = 3'd2,
        WB_OP_LH  = 3'd3,
        WB_OP_LHU = 3'd4,
        WB_OP_LW  = 3'd5,
        WB_OP_LWL = 3'd6,
        WB_OP_LWR = 3'd7
    } wb_op_e;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic [3:0]    be;
    } wb_entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    function automatic logic [DW-1:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/mips_load_align.sv
// Combinational load formatter: extracts, extends and lane-positions load data (big-endian).
// Zero latency; no flow control of its own.
module mips_load_align
    import mips_wb_pkg::*;
(
    input  logic [2:0]    i_op,
    input  logic [1:0]    i_addr_lo,
    input  logic [DW-1:0] i_mdata,
    input  logic [DW-1:0] i_alu,
    output logic [DW-1:0] o_data,
    output logic [3:0]    o_be,
    output logic          o_misaligned
);

    logic [1:0]  w_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Big-endian: offset 0 is the most significant byte of the word.
    assign w_sh   = 2'd3 - i_addr_lo;
    assign w_byte = i_mdata[{w_sh, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_mdata[15:0] : i_mdata[31:16];

    always_comb begin
        o_data       = '0;
        o_be         = 4'hF;
        o_misaligned = 1'b0;
        case (i_op)
            WB_OP_ALU: o_data = i_alu;
            WB_OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            WB_OP_LBU: o_data = {24'd0, w_byte};
            WB_OP_LH: begin
                o_data       = {{16{w_half[15]}}, w_half};
                o_misaligned = i_addr_lo[0];
            end
            WB_OP_LHU: begin
                o_data       = {16'd0, w_half};
                o_misaligned = i_addr_lo[0];
            end
            WB_OP_LW: begin
                o_data       = i_mdata;
                o_misaligned = (i_addr_lo != 2'd0);
            end
            WB_OP_LWL: begin
                o_data = i_mdata << {i_addr_lo, 3'b000};
                o_be   = 4'hF << i_addr_lo;
            end
            WB_OP_LWR: begin
                o_data = i_mdata >> {w_sh, 3'b000};
                o_be   = 4'hF >> w_sh;
            end
            default: o_data = i_alu;
        endcase
    end

endmodule

// File: rtl/mips_load_writeback.sv
// Writeback stage: formats MEM results into a 2-entry skid buffer draining to an arbitrated RF write port.
// Accept at edge N shows rf_wen after N; in_ready is registered (not full) and never depends on rf_gnt.
module mips_load_writeback
    import mips_wb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [1:0]    in_addr_lo,
    input  logic [AW-1:0] in_rd,
    input  logic          in_regwrite,
    input  logic [DW-1:0] in_alu,
    input  logic [DW-1:0] in_mdata,
    input  logic          rf_gnt,
    output logic          rf_wen,
    output logic [AW-1:0] rf_dadd,
    output logic [DW-1:0] rf_data,
    output logic          rf_wen_4,
    output logic          rf_wen_3,
    output logic          rf_wen_2,
    output logic          rf_wen_1,
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_rd,
    output logic [DW-1:0] fwd_data,
    output logic          adel
);

    buf_state_e r_state;
    buf_state_e w_state_nxt;
    wb_entry_t  r_head;
    wb_entry_t  r_tail;
    logic       r_in_ready;
    logic       r_adel;

    logic [DW-1:0] w_fmt_data;
    logic [3:0]    w_fmt_be;
    logic          w_misaligned;
    wb_entry_t     w_new;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_head_vld;
    logic          w_ld_head_new;
    logic          w_ld_tail_new;
    logic          w_shift;

    mips_load_align u_align (
        .i_op         (in_op),
        .i_addr_lo    (in_addr_lo),
        .i_mdata      (in_mdata),
        .i_alu        (in_alu),
        .o_data       (w_fmt_data),
        .o_be         (w_fmt_be),
        .o_misaligned (w_misaligned)
    );

    assign w_new      = '{rd: in_rd, data: w_fmt_data, be: w_fmt_be};
    assign w_accept   = in_valid & r_in_ready;
    // Dropped results are still consumed; they just never occupy a slot.
    assign w_push     = w_accept & in_regwrite & (in_rd != '0) & ~w_misaligned;
    assign w_head_vld = (r_state != BUF_EMPTY);
    assign w_pop      = w_head_vld & rf_gnt;

    always_comb begin
        w_state_nxt   = r_state;
        w_ld_head_new = 1'b0;
        w_ld_tail_new = 1'b0;
        w_shift       = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_push) begin
                    w_state_nxt   = BUF_ONE;
                    w_ld_head_new = 1'b1;
                end
            end
            BUF_ONE: begin
                if (w_push && w_pop) begin
                    w_ld_head_new = 1'b1;
                end else if (w_push) begin
                    w_state_nxt   = BUF_TWO;
                    w_ld_tail_new = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (w_pop) begin
                    w_state_nxt = BUF_ONE;
                    w_shift     = 1'b1;
                end
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BUF_EMPTY;
            r_in_ready <= 1'b0;
            r_adel     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != BUF_TWO);
            r_adel     <= w_accept & w_misaligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_ld_head_new) begin
                r_head <= w_new;
            end else if (w_shift) begin
                r_head <= r_tail;
            end
            if (w_ld_tail_new) begin
                r_tail <= w_new;
            end
        end
    end

    // Gate head fields with validity so a popped entry never leaks onto the port.
    assign in_ready  = r_in_ready;
    assign rf_wen    = w_head_vld;
    assign rf_dadd   = w_head_vld ? r_head.rd : '0;
    assign rf_data   = w_head_vld ? r_head.data : '0;
    assign rf_wen_4  = w_head_vld & r_head.be[3];
    assign rf_wen_3  = w_head_vld & r_head.be[2];
    assign rf_wen_2  = w_head_vld & r_head.be[1];
    assign rf_wen_1  = w_head_vld & r_head.be[0];
    assign fwd_valid = w_head_vld;
    assign fwd_rd    = rf_dadd;
    assign fwd_data  = rf_data & be_to_mask({rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1});
    assign adel      = r_adel;

endmodule

// File: tb/tb_mips_load_writeback.sv
// Bench for mips_load_writeback: table-driven load formatting plus hand sequences for backpressure, drops and async reset.
module tb_mips_load_writeback;
    import mips_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [1:0]  in_addr_lo = 2'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        in_regwrite = 1'b0;
    logic [31:0] in_alu = 32'd0;
    logic [31:0] in_mdata = 32'd0;
    logic        rf_gnt = 1'b0;
    logic        rf_wen;
    logic [4:0]  rf_dadd;
    logic [31:0] rf_data;
    logic        rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        adel;

    mips_load_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_addr_lo  (in_addr_lo),
        .in_rd       (in_rd),
        .in_regwrite (in_regwrite),
        .in_alu      (in_alu),
        .in_mdata    (in_mdata),
        .rf_gnt      (rf_gnt),
        .rf_wen      (rf_wen),
        .rf_dadd     (rf_dadd),
        .rf_data     (rf_data),
        .rf_wen_4    (rf_wen_4),
        .rf_wen_3    (rf_wen_3),
        .rf_wen_2    (rf_wen_2),
        .rf_wen_1    (rf_wen_1),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .adel        (adel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  a;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] md;
        logic [31:0] ed;
        logic [3:0]  ebe;
    } vec_t;

    localparam int NVEC = 14;
    vec_t  vt [NVEC];
    exp_t  sb_q [$];
    exp_t  cur_exp;
    exp_t  mon_e;
    logic  cur_push = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    retires = 0;
    int    retires_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] be);
        logic [31:0] m;
        m = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) m[8*k +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Expected result enters the scoreboard on the cycle the driven stimulus is accepted.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready && cur_push) sb_q.push_back(cur_exp);
    end

    always @(negedge clk) begin
        if (rst_n && rf_wen) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual dadd=%h data=%h expected no write", rf_dadd, rf_data);
            end else begin
                mon_e = sb_q[0];
                check("rf_dadd", 32'(rf_dadd), 32'(mon_e.rd));
                check("rf_data_lanes", rf_data & lanes(mon_e.be), mon_e.data);
                check("rf_be", 32'({rf_wen_4, rf_wen_3, rf_wen_2, rf_wen_1}), 32'(mon_e.be));
                check("fwd_data", fwd_data, mon_e.data);
                check("fwd_rd", 32'(fwd_rd), 32'(mon_e.rd));
                check("fwd_valid", 32'(fwd_valid), 32'd1);
                if (rf_gnt) begin
                    void'(sb_q.pop_front());
                    retires++;
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [1:0] a, input logic [4:0] rd,
                        input logic rw, input logic [31:0] alu, input logic [31:0] md,
                        input logic push, input logic [31:0] ed, input logic [3:0] ebe);
        int  n;
        logic got;
        in_op = op; in_addr_lo = a; in_rd = rd; in_regwrite = rw;
        in_alu = alu; in_mdata = md;
        cur_exp = '{rd: rd, data: ed, be: ebe};
        cur_push = push;
        in_valid = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cur_push = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual in_ready=0 for 50 cycles expected accept");
        end
    endtask

    task automatic drain();
        int n;
        rf_gnt = 1'b1;
        n = 0;
        while (rf_wen && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_rf_wen", 32'(rf_wen), 32'd0);
        check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{WB_OP_LB,  2'd1, 5'd3,  32'd0,        32'h12803456, 32'hFFFFFF80, 4'hF};
        vt[1]  = '{WB_OP_LBU, 2'd1, 5'd4,  32'd0,        32'h12803456, 32'h00000080, 4'hF};
        vt[2]  = '{WB_OP_LH,  2'd2, 5'd6,  32'd0,        32'h12803456, 32'h00003456, 4'hF};
        vt[3]  = '{WB_OP_LH,  2'd0, 5'd7,  32'd0,        32'h9ABC1234, 32'hFFFF9ABC, 4'hF};
        vt[4]  = '{WB_OP_LHU, 2'd0, 5'd9,  32'd0,        32'h9ABC1234, 32'h00009ABC, 4'hF};
        vt[5]  = '{WB_OP_LB,  2'd3, 5'd2,  32'd0,        32'h12803456, 32'h00000056, 4'hF};
        vt[6]  = '{WB_OP_LBU, 2'd0, 5'd2,  32'd0,        32'hF0000000, 32'h000000F0, 4'hF};
        vt[7]  = '{WB_OP_LW,  2'd0, 5'd13, 32'd0,        32'hDEADBEEF, 32'hDEADBEEF, 4'hF};
        vt[8]  = '{WB_OP_ALU, 2'd2, 5'd31, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 4'hF};
        vt[9]  = '{WB_OP_LWL, 2'd1, 5'd8,  32'd0,        32'hAABBCCDD, 32'hBBCCDD00, 4'hE};
        vt[10] = '{WB_OP_LWR, 2'd1, 5'd8,  32'd0,        32'hAABBCCDD, 32'h0000AABB, 4'h3};
        vt[11] = '{WB_OP_LWL, 2'd3, 5'd8,  32'd0,        32'h11223344, 32'h44000000, 4'h8};
        vt[12] = '{WB_OP_LWR, 2'd0, 5'd8,  32'd0,        32'h11223344, 32'h00000011, 4'h1};
        vt[13] = '{WB_OP_LWR, 2'd3, 5'd1,  32'd0,        32'h11223344, 32'h11223344, 4'hF};

        // Reset held with a valid write presented.
        in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd7; in_op = WB_OP_ALU; in_alu = 32'h55;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rf_wen", 32'(rf_wen), 32'd0);
        check("reset_adel", 32'(adel), 32'd0);
        check("reset_fwd_valid", 32'(fwd_valid), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_rf_wen", 32'(rf_wen), 32'd0);

        // Formatting table, port always granted so accept and retire overlap.
        rf_gnt = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            send(vt[i].op, vt[i].a, vt[i].rd, 1'b1, vt[i].alu, vt[i].md, 1'b1, vt[i].ed, vt[i].ebe);
        end
        drain();
        check("table_retires", 32'(retires), 32'(NVEC));

        // Backpressure: three ALU writes with the port withheld.
        retires_base = retires;
        rf_gnt = 1'b0;
        in_op = WB_OP_ALU; in_regwrite = 1'b1; in_addr_lo = 2'd0;
        in_rd = 5'd10; in_alu = 32'hA0A0A0A0;
        cur_exp = '{rd: 5'd10, data: 32'hA0A0A0A0, be: 4'hF};
        cur_push = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready0", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_rd = 5'd11; in_alu = 32'hB1B1B1B1;
        cur_exp = '{rd: 5'd11, data: 32'hB1B1B1B1, be: 4'hF};
        @(negedge clk);
        check("bp_ready1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_rd = 5'd12; in_alu = 32'hC2C2C2C2;
        cur_exp = '{rd: 5'd12, data: 32'hC2C2C2C2, be: 4'hF};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_full", 32'(in_ready), 32'd0);
            check("bp_hold_dadd", 32'(rf_dadd), 32'd10);
            check("bp_hold_data", rf_data, 32'hA0A0A0A0);
        end
        @(posedge clk); #1;
        rf_gnt = 1'b1;
        @(negedge clk);
        check("bp_retire1_wen", 32'(rf_wen), 32'd1);
        @(negedge clk);
        check("bp_retire2_wen", 32'(rf_wen), 32'd1);
        check("bp_ready_again", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; cur_push = 1'b0;
        @(negedge clk);
        check("bp_retire3_wen", 32'(rf_wen), 32'd1);
        check("bp_retire3_dadd", 32'(rf_dadd), 32'd12);
        @(posedge clk); #1;
        check("bp_empty", 32'(rf_wen), 32'd0);
        check("bp_retires", 32'(retires - retires_base), 32'd3);

        // Drops: misaligned halfword, rd=0, and a non-writing instruction.
        retires_base = retires;
        send(WB_OP_LH, 2'd1, 5'd5, 1'b1, 32'd0, 32'h12345678, 1'b0, 32'd0, 4'h0);
        check("mis_adel_pulse", 32'(adel), 32'd1);
        check("mis_no_wen", 32'(rf_wen), 32'd0);
        @(posedge clk); #1;
        check("mis_adel_clear", 32'(adel), 32'd0);
        send(WB_OP_LW, 2'd2, 5'd6, 1'b1, 32'd0, 32'h12345678, 1'b0, 32'd0, 4'h0);
        check("misw_adel_pulse", 32'(adel), 32'd1);
        send(WB_OP_ALU, 2'd0, 5'd0, 1'b1, 32'h77, 32'd0, 1'b0, 32'd0, 4'h0);
        check("rd0_no_adel", 32'(adel), 32'd0);
        check("rd0_no_wen", 32'(rf_wen), 32'd0);
        send(WB_OP_ALU, 2'd0, 5'd9, 1'b0, 32'h88, 32'd0, 1'b0, 32'd0, 4'h0);
        check("norw_no_wen", 32'(rf_wen), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("drop_retires", 32'(retires - retires_base), 32'd0);

        // Async reset while full and stalled.
        rf_gnt = 1'b0;
        send(WB_OP_ALU, 2'd0, 5'd20, 1'b1, 32'h20202020, 32'd0, 1'b1, 32'h20202020, 4'hF);
        send(WB_OP_ALU, 2'd0, 5'd21, 1'b1, 32'h21212121, 32'd0, 1'b1, 32'h21212121, 4'hF);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_rf_wen", 32'(rf_wen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rf_wen", 32'(rf_wen), 32'd0);
        check("arst_fwd_valid", 32'(fwd_valid), 32'd0);
        sb_q.delete();
        retires_base = retires;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rf_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("arst_no_stale", 32'(rf_wen), 32'd0);
        end
        check("arst_retires", 32'(retires - retires_base), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
